// File: rtl/nibble_rx_fifo.sv
// rtl/nibble_rx_fifo.sv - serial bit assembler feeding a word FIFO with registered read port
module nibble_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    S_in,
  input  logic                    bit_valid,
  input  logic                    dir,
  input  logic                    flush,
  input  logic                    rd_en,
  input  logic                    clr_ovf,
  output logic [WIDTH-1:0]        D_out,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BCNT_ONE  = BW'(1);

  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rdv_q, rdv_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] word_nxt;
  logic             word_done;
  logic             pop;
  logic             push;
  logic             drop;
  logic             mem_we;

  // Decode this edge's events: the shifted word, completion, pop, accepted push, dropped word
  always_comb begin
    word_nxt  = dir ? {asm_q[WIDTH-2:0], S_in} : {S_in, asm_q[WIDTH-1:1]};
    word_done = bit_valid && (bcnt_q == BCNT_LAST);
    pop       = rd_en && (count_q != '0);
    // A pop on a full FIFO frees the slot the completing word lands in
    push      = word_done && ((count_q != DEPTH_C) || pop);
    drop      = word_done && (count_q == DEPTH_C) && !pop;
    mem_we    = push && !flush;
  end

  // Next-state logic; flush overrides assembly and reads but leaves D_out untouched
  always_comb begin
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    dout_d  = dout_q;
    rdv_d   = 1'b0;
    if (flush) begin
      bcnt_d  = '0;
      asm_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (bit_valid) begin
        asm_d  = word_nxt;
        bcnt_d = word_done ? '0 : bcnt_q + BCNT_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
        dout_d = mem[rptr_q];
        rdv_d  = 1'b1;
      end
      if (push) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // A drop on the same edge as clr_ovf keeps the flag set
      if (drop) begin
        ovf_d = 1'b1;
      end else if (clr_ovf) begin
        ovf_d = 1'b0;
      end
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q  <= '0;
      asm_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      rdv_q   <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      rdv_q   <= rdv_d;
    end
  end

  // Word storage has no reset; a slot is only read after it has been written
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_q] <= word_nxt;
    end
  end

  // Status outputs are derived from the stored-word count
  always_comb begin
    D_out    = dout_q;
    rd_valid = rdv_q;
    count    = count_q;
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_nibble_rx_fifo.sv
// tb/tb_nibble_rx_fifo.sv - scoreboard bench for nibble_rx_fifo
module tb_nibble_rx_fifo;

  logic       clk;
  logic       reset;
  logic       S_in;
  logic       bit_valid;
  logic       dir;
  logic       flush;
  logic       rd_en;
  logic       clr_ovf;
  logic [3:0] D_out;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  int         mbcnt;
  logic [3:0] masm;
  logic [3:0] mdout;
  logic       movf;
  logic [3:0] mq[$];

  nibble_rx_fifo #(.DEPTH(8), .WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .S_in      (S_in),
    .bit_valid (bit_valid),
    .dir       (dir),
    .flush     (flush),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .D_out     (D_out),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbcnt = 0;
    masm  = 4'h0;
    mdout = 4'h0;
    movf  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_dout"},  D_out,    mdout);
    check_eq({tag, "_count"}, count,    mq.size());
    check_eq({tag, "_empty"}, empty,    mq.size() == 0);
    check_eq({tag, "_full"},  full,     mq.size() == 8);
    check_eq({tag, "_ovf"},   overflow, movf);
  endtask

  // One clock: update the model, drive inputs, sample 1ns after the edge
  task automatic step(input logic bv, input logic s, input logic d, input logic rd,
                      input logic fl, input logic co);
    logic       exp_pop;
    logic       set_ovf;
    logic [3:0] nw;
    exp_pop = 1'b0;
    set_ovf = 1'b0;
    if (fl) begin
      mq.delete();
      mbcnt = 0;
      masm  = 4'h0;
      movf  = 1'b0;
    end else begin
      if (rd && mq.size() > 0) begin
        exp_pop = 1'b1;
        mdout   = mq.pop_front();
      end
      if (bv) begin
        nw   = d ? {masm[2:0], s} : {s, masm[3:1]};
        masm = nw;
        if (mbcnt == 3) begin
          mbcnt = 0;
          if (mq.size() < 8) mq.push_back(nw);
          else set_ovf = 1'b1;
        end else begin
          mbcnt++;
        end
      end
      if (set_ovf) movf = 1'b1;
      else if (co) movf = 1'b0;
    end
    bit_valid = bv;
    S_in      = s;
    dir       = d;
    rd_en     = rd;
    flush     = fl;
    clr_ovf   = co;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    S_in      = 1'b0;
    rd_en     = 1'b0;
    flush     = 1'b0;
    clr_ovf   = 1'b0;
    check_eq("rd_valid", rd_valid, exp_pop);
    check_status("step");
  endtask

  task automatic send_word(input logic [3:0] w, input logic d, input logic rd_last,
                           input logic co_last);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d ? w[3-i] : w[i], d, rd_last && (i == 3), 1'b0, co_last && (i == 3));
    end
  endtask

  task automatic read_one();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    S_in      = 1'b0;
    bit_valid = 1'b0;
    dir       = 1'b0;
    flush     = 1'b0;
    rd_en     = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();
    #2;
    check_eq("rst_rdv", rd_valid, 1'b0);
    check_status("rst");
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // dir=1, bits 1,0,1,1 -> 4'hB
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("msb_count", count, 4'd1);
    read_one();
    check_eq("msb_word", D_out, 4'hB);

    // dir=0, same bits -> 4'hD
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    read_one();
    check_eq("lsb_word", D_out, 4'hD);

    // Nine words with no reads: full after 8, overflow on the ninth
    for (int i = 0; i < 9; i++) begin
      send_word(4'(i), 1'b1, 1'b0, 1'b0);
      if (i == 7) check_eq("fill_full", full, 1'b1);
    end
    check_eq("fill_ovf", overflow, 1'b1);
    for (int i = 0; i < 8; i++) read_one();
    check_eq("drain_empty", empty, 1'b1);
    check_eq("drain_last", D_out, 4'h7);
    read_one();
    check_eq("empty_rd", rd_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("clr_ovf", overflow, 1'b0);

    // Full FIFO, word completes while reading: no overflow, new word last
    for (int i = 0; i < 8; i++) send_word(4'(8 + i), 1'b1, 1'b0, 1'b0);
    send_word(4'hA, 1'b1, 1'b1, 1'b0);
    check_eq("full_rw_ovf", overflow, 1'b0);
    check_eq("full_rw_cnt", count, 4'd8);
    for (int i = 0; i < 8; i++) read_one();
    check_eq("full_rw_last", D_out, 4'hA);

    // Overflow set and clr_ovf together: set wins
    for (int i = 0; i < 8; i++) send_word(4'(i), 1'b0, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0, 1'b1);
    check_eq("ovf_set_wins", overflow, 1'b1);

    // Flush mid-word clears everything but D_out
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("flush_cnt", count, 4'd0);
    check_eq("flush_ovf", overflow, 1'b0);
    send_word(4'h9, 1'b1, 1'b0, 1'b0);
    read_one();
    check_eq("post_flush", D_out, 4'h9);

    // Two bits, async reset mid-cycle, then 0,1,1,0 -> 4'h6
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_rdv", rd_valid, 1'b0);
    check_status("mid_rst");
    #2;
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_cnt", count, 4'd1);
    read_one();
    check_eq("rst_word", D_out, 4'h6);

    // Empty FIFO, word completes with rd_en: no bypass
    send_word(4'h3, 1'b1, 1'b1, 1'b0);
    check_eq("nobyp_rdv", rd_valid, 1'b0);
    check_eq("nobyp_cnt", count, 4'd1);
    read_one();
    check_eq("nobyp_word", D_out, 4'h3);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
